// File: rtl/rf_write_buffer.sv
// In-order write queue in front of the register file write port, with two-port hazard lookup and forwarding.
// Latency: a write accepted at edge N is visible on rf_* and in the lookup from cycle N+1; lookup and rf_wen are combinational.
// Backpressure: in_ready = !full (no same-cycle bypass); draining is gated by drain_en, one entry per cycle.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset (clears pointers, count, valid flags)
//   in_valid/in_ready        writeback handshake; in_addr/in_data hold the result (x0 writes are dropped)
//   drain_en                 register file write port is free this cycle
//   rf_wen/rf_waddr/rf_wdata register file write port, driven from the head entry
//   raddr1/raddr2            decode read indices; hit1/hit2 and fwd_data1/fwd_data2 give the youngest pending write
//   count/empty/full         occupancy

module rf_write_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    drain_en,
  output logic                    rf_wen,
  output logic [ADDR_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr1,
  input  logic [ADDR_WIDTH-1:0]   raddr2,
  output logic                    hit1,
  output logic                    hit2,
  output logic [DATA_WIDTH-1:0]   fwd_data1,
  output logic [DATA_WIDTH-1:0]   fwd_data2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage and bookkeeping
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic push;
  logic pop;

  // Occupancy and handshake
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    count    = count_q;
    in_ready = !full;
  end

  // A handshake to x0 completes but stores nothing: x0 is hardwired zero.
  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop  = rf_wen;

  // Drain port always presents the head; wen alone qualifies it.
  always_comb begin
    rf_wen   = !empty && drain_en;
    rf_waddr = addr_q[rd_ptr_q];
    rf_wdata = data_q[rd_ptr_q];
  end

  // Next-state for pointers, count and valid flags.
  // Push and pop never target the same slot: that needs empty (no pop) or full (no push).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if (push) begin
      addr_d[wr_ptr_q] = in_addr;
      data_d[wr_ptr_q] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload is not reset: every consumer is gated by valid_q or rf_wen.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Youngest-match lookup. Walking from the head (oldest) towards the tail
  // and letting later matches overwrite earlier ones yields the youngest entry.
  // The head is searched even when it is popping this cycle, since the
  // register file has not been written yet.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] raddr);
    logic [DATA_WIDTH:0] res;
    logic [PW-1:0]       idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == raddr) && (raddr != '0)) begin
        res = {1'b1, data_q[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {hit1, fwd_data1} = lookup(raddr1);
    {hit2, fwd_data2} = lookup(raddr2);
  end

endmodule

// File: doc/rf_write_buffer.md
Name: rf_write_buffer

Overview:
- Small in-order write queue that sits in front of the register file write port (wen/waddr/wdata). It is the initiator side of that port.
- Accepts writeback results from the pipeline over a valid/ready handshake and drains them into the register file one per cycle.
- Gives the decode stage hazard lookup with data forwarding for two read addresses, so reads never observe a stale register value.

Parameters:
- ADDR_WIDTH, 5, register index width; must match the register file.
- DATA_WIDTH, 32, register data width.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a writeback result is offered.
- in_ready  out  1  buffer can accept; equals !full (no same-cycle bypass).
- in_addr  in  ADDR_WIDTH  destination register index.
- in_data  in  DATA_WIDTH  value to write.
- drain_en  in  1  register file write port is available this cycle.
- rf_wen  out  1  drives the register file wen.
- rf_waddr  out  ADDR_WIDTH  drives the register file waddr.
- rf_wdata  out  DATA_WIDTH  drives the register file wdata.
- raddr1, raddr2  in  ADDR_WIDTH  decode-stage read indices.
- hit1, hit2  out  1  a pending write to raddrN is queued.
- fwd_data1, fwd_data2  out  DATA_WIDTH  data of the youngest queued write to raddrN; 0 when no hit.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty, full  out  1  occupancy flags.

Behaviour:
- Reset: the asynchronous rst_n low clears wr_ptr, rd_ptr and count immediately.
  - While in reset: empty=1, full=0, in_ready=1, rf_wen=0, hit1=hit2=0, fwd_data=0, count=0.
  - Entry contents are don't-care after reset; all valid flags are cleared.
  - Reset asserted mid-operation discards all pending writes. rf_wen drops in the same cycle, without waiting for clk.
- Enqueue happens on a clock edge when in_valid && in_ready.
  - If in_addr != 0: store {in_addr, in_data} at wr_ptr, then increment wr_ptr modulo DEPTH.
  - If in_addr == 0: the handshake completes but nothing is enqueued (x0 is hardwired zero).
- Drain:
  - rf_wen = !empty && drain_en (combinational).
  - rf_waddr and rf_wdata always reflect the head entry at rd_ptr.
  - When rf_wen=1, the head pops at the clock edge; rd_ptr increments modulo DEPTH.
  - Latency: a write enqueued at edge N can appear on the rf_* ports in cycle N+1, at the earliest.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance.
  - When full, enqueue is blocked even if a drain occurs that cycle.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. full = (count == DEPTH); empty = (count == 0).
- Order: entries drain strictly in enqueue order. Multiple entries to the same address are all written, oldest first.
- Lookup (combinational, per read port):
  - Search all valid entries, including the head being drained this cycle.
  - hitN=1 if any entry address equals raddrN.
  - fwd_dataN = data of the youngest such entry, by enqueue order relative to rd_ptr.
  - raddrN == 0 gives hitN=0 and fwd_dataN=0.
  - The in_* port is not included in the lookup (no same-cycle bypass).
- in_valid with in_ready=0 is legal. The producer holds in_addr/in_data stable until accepted.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle -> immediately empty=1, rf_wen=0, count=0, in_ready=1.
- Single write: enqueue (addr 5, 0xDEADBEEF) with drain_en=0.
  - Next cycle: count=1, hit1=1, fwd_data1=0xDEADBEEF for raddr1=5, rf_wen=0.
  - Raise drain_en -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF for one cycle, then empty=1.
- Fill/full: drain_en=0, enqueue 4 writes to addrs 1..4.
  - Result: full=1, in_ready=0; a 5th in_valid is held and not accepted.
  - Set drain_en=1 -> drains addrs 1,2,3,4 in order over 4 cycles; the held 5th write is accepted the cycle after the first pop.
- Same-address youngest: enqueue (7,0x11) then (7,0x22), drain_en=0.
  - Result: fwd_data2=0x22 for raddr2=7.
  - After one drain: rf_wdata was 0x11 and fwd_data2 stays 0x22.
  - After the second drain: hit2=0, fwd_data2=0.
- x0 handling: enqueue (0,0xFFFF) -> handshake completes, count stays 0, rf_wen never asserts; raddr1=0 -> hit1=0, fwd_data1=0.
- Wrap and concurrent traffic: in_valid=1 and drain_en=1 for 10 cycles with addrs 1..10.
  - Result: count stays 1 after the first cycle, pointers wrap, rf_waddr sequence is 1..10 with no loss or duplication.
- Reset mid-traffic: assert rst_n=0 with 3 entries queued -> rf_wen=0 immediately and no further writes after rst_n is released.
